// File: rtl/jts16_snd_mailbox.sv
// rtl/jts16_snd_mailbox.sv - Sound-CPU end of the main-to-sound command FIFO with NMI pacing.
// Optional status port enabled by defining JTS16_MBOX_STATUS_EN.
module jts16_snd_mailbox #(
    parameter int         DW_LOG2  = 2,
    parameter int         NMI_GAP  = 4,
    parameter logic [1:0] PORT_SEL = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] snd_latch,
    input  logic       snd_irqn,
    output logic       snd_ack,
    input  logic [7:0] z_addr,
    input  logic       z_iorq_n,
    input  logic       z_rd_n,
    input  logic       z_m1_n,
    output logic [7:0] z_dout,
    output logic       nmi_n
);
    localparam int DEPTH = 1 << DW_LOG2;
    localparam int CW    = DW_LOG2 + 1;
    localparam int GW    = (NMI_GAP < 1) ? 1 : $clog2(NMI_GAP + 1);
    localparam logic [DW_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0]      CNT_ONE  = 1;
    localparam logic [CW-1:0]      CNT_FULL = CW'(DEPTH);
    localparam logic [GW-1:0]      GAP_ONE  = 1;
    localparam logic [GW-1:0]      GAP_LOAD = GW'(NMI_GAP);

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [DW_LOG2-1:0] r_wptr, r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_ovf, r_ack, r_irqn, r_rd, r_rd_d, r_addr0;
    logic [7:0]         r_dout;
    state_t             r_state;
    logic [GW-1:0]      r_gap;

    logic          w_rd_act, w_fire, w_push, w_push_ok, w_pop, w_stat_rd;
    logic          w_full, w_empty;
    logic [CW-1:0] w_count_nx;
    logic [7:0]    w_status;
    state_t        w_state_nx;
    logic [GW-1:0] w_gap_nx;
    logic          w_unused_addr;

    assign w_rd_act  = ~z_iorq_n & ~z_rd_n & z_m1_n & (z_addr[7:6] == PORT_SEL);
    assign w_fire    = r_rd & ~r_rd_d;
    assign w_push    = r_irqn & ~snd_irqn;
    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_pop     = w_fire & ~r_addr0 & ~w_empty;
    // A pop in the same clk frees the slot the push needs, so a full FIFO still accepts it
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_stat_rd = w_fire & r_addr0;
    assign w_unused_addr = ^z_addr[5:1];

`ifdef JTS16_MBOX_STATUS_EN
    assign w_status = {w_full, w_empty, r_ovf, 2'b00, 3'(r_count)};
`else
    logic w_unused_ovf;
    assign w_unused_ovf = r_ovf | w_stat_rd;
    assign w_status     = 8'hFF;
`endif

    always_comb begin
        w_count_nx = r_count;
        if (w_push_ok && !w_pop)
            w_count_nx = r_count + CNT_ONE;
        else if (!w_push_ok && w_pop)
            w_count_nx = r_count - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= 8'h00;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ack   <= 1'b1;
            r_irqn  <= 1'b1;
            r_rd    <= 1'b0;
            r_rd_d  <= 1'b0;
            r_addr0 <= 1'b0;
            r_dout  <= 8'hFF;
        end else begin
            r_irqn  <= snd_irqn;
            r_rd    <= w_rd_act;
            r_rd_d  <= r_rd;
            r_addr0 <= z_addr[0];
            if (w_push_ok) begin
                r_mem[r_wptr] <= snd_latch;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            r_count <= w_count_nx;
            r_ack   <= ~w_full;
            if (w_fire)
                r_dout <= r_addr0 ? w_status : (w_empty ? 8'hFF : r_mem[r_rptr]);
`ifdef JTS16_MBOX_STATUS_EN
            if (w_stat_rd)
                r_ovf <= 1'b0;
`endif
            if (w_push && !w_push_ok)
                r_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gap_nx   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty)
                    w_state_nx = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (w_pop) begin
                    if (w_count_nx != '0) begin
                        w_state_nx = ST_GAP;
                        w_gap_nx   = GAP_LOAD;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                // Leaving on the clk the counter reaches 0 keeps nmi_n high for exactly NMI_GAP clks
                if (r_gap <= GAP_ONE) begin
                    w_gap_nx   = '0;
                    w_state_nx = w_empty ? ST_IDLE : ST_ASSERT;
                end else begin
                    w_gap_nx = r_gap - GAP_ONE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gap   <= w_gap_nx;
        end
    end

    assign snd_ack = r_ack;
    assign z_dout  = r_dout;
    assign nmi_n   = (r_state != ST_ASSERT);
endmodule

// File: doc/jts16_snd_mailbox.md
Name: jts16_snd_mailbox

Overview:
- Sound-CPU end of the main-to-sound command channel.
- Main side: on each falling edge of snd_irqn, captures the 8-bit command on snd_latch into a small FIFO and reports free space on snd_ack.
- Sound side: the Z80 gets an NMI whenever commands are pending and pops one command per IN from the latch port.
- Sits between the main board's 8255 port A/C pins and the sound Z80 bus decoder.

Parameters:
- DW_LOG2, 2, log2 of FIFO depth (4 entries).
- NMI_GAP, 4, clk cycles nmi_n is held high between back-to-back NMIs.
- PORT_SEL, 2'b11, value of z_addr[7:6] that selects the mailbox I/O ports.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- snd_latch  in  8  command byte from main PPI port A.
- snd_irqn  in  1  main-side request, active low, synchronous to clk; falling edge = new command.
- snd_ack  out  1  high when FIFO is not full; feeds main PPI port C bit 6.
- z_addr  in  8  Z80 I/O address, low byte.
- z_iorq_n  in  1  Z80 IORQ.
- z_rd_n  in  1  Z80 RD.
- z_m1_n  in  1  Z80 M1; low means interrupt acknowledge, not an I/O read.
- z_dout  out  8  data to Z80 bus.
- nmi_n  out  1  Z80 NMI request, active low.

Behaviour:
- Reset values:
  - FIFO empty, read/write pointers 0, count 0, overflow flag 0.
  - snd_ack=1, nmi_n=1, z_dout=8'hFF, NMI FSM in IDLE.
- Push:
  - Trigger: snd_irqn registered each clk; push when the previous sample is 1 and the current sample is 0.
  - snd_latch is written at the write pointer on that clk.
  - Full at push: byte dropped, overflow flag set (sticky).
  - snd_irqn held low produces only one push.
- Read access:
  - rd_act = !z_iorq_n & !z_rd_n & z_m1_n & z_addr[7:6]==PORT_SEL.
  - Action fires on the rising edge of rd_act, one clk after detection.
- Latch port, z_addr[0]=0:
  - z_dout <= FIFO head, or 8'hFF if empty.
  - If not empty: pop, read pointer +1 with modulo wrap.
  - z_dout holds its value until the next read action.
- Status port, z_addr[0]=1: see Optional Feature.
- Count, pointers and flags:
  - Count width is DW_LOG2+1; pointers wrap modulo 2**DW_LOG2.
  - snd_ack is registered: = ~full, updates one clk after a count change.
- Simultaneous push and pop in the same clk:
  - Pop uses the pre-push state.
  - Full + pop: push accepted, no overflow, count unchanged.
  - Empty + pop: read returns 8'hFF, push stored, count becomes 1.
- NMI FSM:
  - IDLE: nmi_n=1. Go to ASSERT when count!=0 (nmi_n low one clk after the first push).
  - ASSERT: nmi_n=0. On a latch-port pop:
    - count after pop >0 → GAP, load gap counter with NMI_GAP.
    - count after pop =0 → IDLE.
  - GAP: nmi_n=1, counter decrements each clk. At 0 → ASSERT if count!=0, else IDLE.
  - Pushes during GAP or ASSERT do not retrigger the FSM.
- Mid-operation reset clears FIFO contents, flags and the FSM immediately; any pending NMI is dropped.

Optional Feature:
- Macro: JTS16_MBOX_STATUS_EN.
- Defined: a status-port read returns {full, empty, overflow, 2'b00, count[2:0]}, with count zero-extended or truncated to 3 bits. The read clears the overflow flag and does not pop.
- Not defined: a status-port read returns 8'hFF. The overflow flag exists but is cleared only by rst.

Test Plan:
- Reset, then a single command: snd_latch=8'h5A, pulse snd_irqn low 3 clk → exactly one push; nmi_n=0 within 2 clk; a Z80 IN from port 8'hC0 gives z_dout=8'h5A; nmi_n=1 after the pop; snd_ack stays 1.
- Fill to full: push 8'h01..8'h04 → snd_ack=0. Push 8'h05 → dropped. Four reads return 01,02,03,04; nmi_n pulses high for NMI_GAP=4 clk between reads; snd_ack=1 after the first pop.
- Pointer wrap: 10 push/pop pairs of 8'h10..8'h19 → data returned in order, count 0 at end.
- Simultaneous push and pop while full (8'hAA..8'hDD queued, push 8'hEE on the pop clk) → read gives AA; count stays 4; no overflow; 8'hEE is the last entry read.
- Empty read, and a read with z_m1_n=0 → z_dout=8'hFF with no state change; the M1 access leaves z_dout untouched.
- With JTS16_MBOX_STATUS_EN: overflow the FIFO, then IN from port 8'hC1 → 8'hA4 (full, overflow, count=4); a second status read → 8'h84. Without the macro, the same status reads → 8'hFF.
